// File: rtl/rsa_pkg.sv
// Shared types and elaboration checks for the streaming RSA modular exponentiation engine.
package rsa_pkg;

  localparam int WIDTH_DEFAULT = 256;

  typedef enum logic [3:0] {
    IDLE, LOAD_M, LOAD_E, LOAD_N, CHECK, SCAN, SQR, MUL, OUT
  } rsa_state_t;

  function automatic bit widths_legal(input int width, input int bus_w);
    return (bus_w > 0) && (width % bus_w == 0) && (width >= 2 * bus_w);
  endfunction

endpackage

// File: rtl/modmul_il.sv
// Interleaved modular multiplier P = A*B mod N, one B bit per cycle, MSB first.
module modmul_il
  import rsa_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] N,
  output logic [WIDTH-1:0] P,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] p_q, a_q, b_q, n_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q, done_q;

  // One double-and-add step; the extra top bit holds 2P and P+A before reduction.
  function automatic logic [WIDTH-1:0] mm_step(input logic [WIDTH-1:0] p,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] n,
                                               input logic             b_bit);
    logic [WIDTH:0] t;
    t = {p, 1'b0};
    if (t >= {1'b0, n}) t = t - {1'b0, n};
    if (b_bit) begin
      t = t + {1'b0, a};
      if (t >= {1'b0, n}) t = t - {1'b0, n};
    end
    return t[WIDTH-1:0];
  endfunction

  // The first bit is folded into the start cycle so the result lands with done.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        p_q   <= mm_step('0, A, N, B[WIDTH-1]);
        a_q   <= A;
        n_q   <= N;
        b_q   <= {B[WIDTH-2:0], 1'b0};
        cnt_q <= CW'(WIDTH - 1);
        run_q <= 1'b1;
      end else if (run_q) begin
        p_q   <= mm_step(p_q, a_q, n_q, b_q[WIDTH-1]);
        b_q   <= {b_q[WIDTH-2:0], 1'b0};
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign P    = p_q;
  assign done = done_q;

endmodule

// File: rtl/rsa_modexp_stream.sv
// Streaming R = M^E mod N engine: word-serial load of M, E, N, left-to-right
// square-and-multiply on one interleaved multiplier, word-serial result.
module rsa_modexp_stream
  import rsa_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int BUS_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BUS_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BUS_W-1:0] out_data,
  output logic             out_last,
  output logic             err,
  output logic             busy
);
  localparam int WORDS = WIDTH / BUS_W;
  localparam int IW    = $clog2(WIDTH);
  localparam int WW    = $clog2(WORDS);

  if (!widths_legal(WIDTH, BUS_W)) begin : g_bad_widths
    $error("rsa_modexp_stream: WIDTH must be a multiple of BUS_W and at least 2*BUS_W");
  end

  rsa_state_t       state_q;
  logic [WIDTH-1:0] m_q, e_q, n_q, c_q;
  logic [IW-1:0]    i_q;
  logic [WW-1:0]    wcnt_q;
  logic             start_q, err_q, out_valid_q, out_last_q;
  logic [BUS_W-1:0] out_data_q;

  logic             beat, word_last, go_out, bad_ops;
  logic [WIDTH-1:0] r_sel, mm_b, mm_p;
  logic             mm_done;

  assign in_ready  = !rst && (state_q inside {IDLE, LOAD_M, LOAD_E, LOAD_N});
  assign beat      = in_valid && in_ready;
  assign word_last = (wcnt_q == WW'(WORDS - 1));
  assign bad_ops   = (n_q < WIDTH'(2)) || (m_q >= n_q);
  assign mm_b      = (state_q == MUL) ? m_q : c_q;

  modmul_il #(.WIDTH(WIDTH)) u_modmul (
    .clk  (clk),
    .rst  (rst),
    .start(start_q),
    .A    (c_q),
    .B    (mm_b),
    .N    (n_q),
    .P    (mm_p),
    .done (mm_done)
  );

  // Every path into OUT funnels through go_out/r_sel so the first result word is registered uniformly.
  always_comb begin
    go_out = 1'b0;
    r_sel  = mm_p;
    unique case (state_q)
      CHECK: begin
        if (bad_ops) begin
          go_out = 1'b1;
          r_sel  = '0;
        end else if (e_q == '0) begin
          go_out = 1'b1;
          r_sel  = WIDTH'(1);
        end
      end
      SCAN: begin
        if (e_q[i_q] && i_q == '0) begin
          go_out = 1'b1;
          r_sel  = m_q;
        end
      end
      SQR:     go_out = mm_done && !e_q[i_q] && (i_q == '0);
      MUL:     go_out = mm_done && (i_q == '0);
      default: go_out = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      m_q         <= '0;
      e_q         <= '0;
      n_q         <= '0;
      c_q         <= '0;
      i_q         <= '0;
      wcnt_q      <= '0;
      start_q     <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (beat) begin
            m_q     <= {m_q[WIDTH-BUS_W-1:0], in_data};
            wcnt_q  <= WW'(1);
            state_q <= LOAD_M;
          end
        end
        LOAD_M: begin
          if (beat) begin
            m_q    <= {m_q[WIDTH-BUS_W-1:0], in_data};
            wcnt_q <= word_last ? '0 : wcnt_q + 1'b1;
            if (word_last) state_q <= LOAD_E;
          end
        end
        LOAD_E: begin
          if (beat) begin
            e_q    <= {e_q[WIDTH-BUS_W-1:0], in_data};
            wcnt_q <= word_last ? '0 : wcnt_q + 1'b1;
            if (word_last) state_q <= LOAD_N;
          end
        end
        LOAD_N: begin
          if (beat) begin
            n_q    <= {n_q[WIDTH-BUS_W-1:0], in_data};
            wcnt_q <= word_last ? '0 : wcnt_q + 1'b1;
            if (word_last) state_q <= CHECK;
          end
        end
        CHECK: begin
          if (bad_ops) err_q <= 1'b1;
          else if (e_q != '0) begin
            i_q     <= IW'(WIDTH - 1);
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (e_q[i_q] && i_q != '0) begin
            c_q     <= m_q;
            start_q <= 1'b1;
            state_q <= SQR;
          end
          i_q <= i_q - 1'b1;
        end
        SQR: begin
          if (mm_done) begin
            c_q <= mm_p;
            if (e_q[i_q]) begin
              start_q <= 1'b1;
              state_q <= MUL;
            end else if (i_q != '0) begin
              i_q     <= i_q - 1'b1;
              start_q <= 1'b1;
            end
          end
        end
        MUL: begin
          if (mm_done) begin
            c_q <= mm_p;
            if (i_q != '0) begin
              i_q     <= i_q - 1'b1;
              start_q <= 1'b1;
              state_q <= SQR;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            if (word_last) begin
              state_q     <= IDLE;
              m_q         <= '0;
              e_q         <= '0;
              n_q         <= '0;
              c_q         <= '0;
              i_q         <= '0;
              wcnt_q      <= '0;
              err_q       <= 1'b0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_data_q  <= '0;
            end else begin
              c_q        <= c_q << BUS_W;
              out_data_q <= c_q[WIDTH-BUS_W-1 -: BUS_W];
              out_last_q <= (wcnt_q == WW'(WORDS - 2));
              wcnt_q     <= wcnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      if (go_out) begin
        c_q         <= r_sel;
        out_data_q  <= r_sel[WIDTH-1 -: BUS_W];
        out_valid_q <= 1'b1;
        out_last_q  <= 1'b0;
        wcnt_q      <= '0;
        state_q     <= OUT;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rsa_modexp_stream.sv
// Directed bench for rsa_modexp_stream: a 64-bit instance for the hand-worked
// vectors and a 128-bit instance for an all-ones exponent against a wide-arithmetic model.
module tb_rsa_modexp_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_err, a_busy;
  logic [31:0] a_in_data, a_out_data;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_err, b_busy;
  logic [31:0] b_in_data, b_out_data;

  rsa_modexp_stream #(.WIDTH(64), .BUS_W(32)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .err(a_err), .busy(a_busy)
  );

  rsa_modexp_stream #(.WIDTH(128), .BUS_W(32)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .err(b_err), .busy(b_busy)
  );

  function automatic logic [127:0] mexp128(input logic [127:0] m, input logic [127:0] e,
                                           input logic [127:0] n);
    logic [255:0] r, nn, mm;
    r  = 256'd1;
    nn = {128'd0, n};
    mm = {128'd0, m};
    for (int i = 127; i >= 0; i--) begin
      r = (r * r) % nn;
      if (e[i]) r = (r * mm) % nn;
    end
    return r[127:0];
  endfunction

  task automatic send_a(input logic [31:0] d, input int gap);
    repeat (gap) begin @(posedge clk); #1; end
    a_in_valid = 1'b1;
    a_in_data  = d;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_in_data  = '0;
  endtask

  task automatic load_a(input logic [63:0] m, input logic [63:0] e, input logic [63:0] n,
                        input int gapmax);
    logic [31:0] w [6];
    w[0] = m[63:32]; w[1] = m[31:0];
    w[2] = e[63:32]; w[3] = e[31:0];
    w[4] = n[63:32]; w[5] = n[31:0];
    for (int k = 0; k < 6; k++)
      send_a(w[k], (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
  endtask

  // Called right after the last N beat; that cycle counts as latency 1.
  task automatic wait_a(output int lat);
    lat = 1;
    while (a_out_valid !== 1'b1 && lat < 5000) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic recv_a(input int hold, output logic [63:0] r, output logic [1:0] errs,
                        output logic [1:0] lasts, output bit stable);
    int          t;
    logic [31:0] held;
    r = '0; errs = '0; lasts = '0; stable = 1'b1;
    for (int w = 0; w < 2; w++) begin
      t = 0;
      while (a_out_valid !== 1'b1 && t < 5000) begin @(posedge clk); #1; t++; end
      held = a_out_data;
      repeat (hold) begin
        @(posedge clk); #1;
        if (a_out_data !== held || a_out_valid !== 1'b1) stable = 1'b0;
      end
      r     = {r[31:0], a_out_data};
      errs  = {errs[0], a_err};
      lasts = {lasts[0], a_out_last};
      a_out_ready = 1'b1;
      @(posedge clk); #1;
      a_out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (a_in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", a_in_ready); end
    n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
    n_cmp++; if (a_out_data !== 32'd0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", a_out_data); end
    n_cmp++; if (a_out_last !== 1'b0 || a_err !== 1'b0) begin n_bad++; $display("FAIL reset_last_err: got %b%b want 00", a_out_last, a_err); end
    n_cmp++; if (b_busy !== 1'b0 || b_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_wide: got %b%b want 00", b_busy, b_out_valid); end
    rst = 1'b0;
    #1;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL idle_in_ready: got %b want 1", a_in_ready); end
  endtask

  task automatic test_basic();
    int lat; logic [63:0] r; logic [1:0] errs, lasts; bit st;
    load_a(64'd4, 64'd13, 64'd497, 0);
    wait_a(lat);
    n_cmp++; if (lat != 388) begin n_bad++; $display("FAIL basic_latency: got %0d want 388", lat); end
    recv_a(0, r, errs, lasts, st);
    n_cmp++; if (r !== 64'd445) begin n_bad++; $display("FAIL basic_result: got %0d want 445", r); end
    n_cmp++; if (errs !== 2'b00) begin n_bad++; $display("FAIL basic_err: got %b want 00", errs); end
    n_cmp++; if (lasts !== 2'b01) begin n_bad++; $display("FAIL basic_last: got %b want 01", lasts); end
    n_cmp++; if (a_busy !== 1'b0 || a_out_valid !== 1'b0 || a_out_data !== 32'd0) begin
      n_bad++; $display("FAIL basic_idle: got busy=%b vld=%b data=%h want 0 0 0", a_busy, a_out_valid, a_out_data); end
  endtask

  task automatic test_toy_rsa();
    int lat; logic [63:0] r; logic [1:0] errs, lasts; bit st;
    load_a(64'd65, 64'd17, 64'd3233, 0);
    wait_a(lat);
    n_cmp++; if (lat != 1 + 60 + 5 * 65 + 1) begin n_bad++; $display("FAIL toy_enc_latency: got %0d want %0d", lat, 1 + 60 + 5 * 65 + 1); end
    recv_a(0, r, errs, lasts, st);
    n_cmp++; if (r !== 64'd2790) begin n_bad++; $display("FAIL toy_encrypt: got %0d want 2790", r); end
    load_a(64'd2790, 64'd2753, 64'd3233, 0);
    wait_a(lat);
    recv_a(0, r, errs, lasts, st);
    n_cmp++; if (r !== 64'd65) begin n_bad++; $display("FAIL toy_decrypt: got %0d want 65", r); end
    n_cmp++; if (errs !== 2'b00) begin n_bad++; $display("FAIL toy_err: got %b want 00", errs); end
  endtask

  task automatic test_zero_exp();
    int lat; logic [63:0] r; logic [1:0] errs, lasts; bit st;
    load_a(64'd5, 64'd0, 64'd7, 0);
    wait_a(lat);
    n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL zero_latency: got %0d want 2", lat); end
    recv_a(0, r, errs, lasts, st);
    n_cmp++; if (r !== 64'd1 || errs !== 2'b00) begin n_bad++; $display("FAIL zero_result: got %0d err=%b want 1 err=00", r, errs); end
  endtask

  task automatic test_errors();
    int lat; logic [63:0] r; logic [1:0] errs, lasts; bit st;
    load_a(64'd7, 64'd3, 64'd7, 0);
    wait_a(lat);
    n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL err_latency: got %0d want 2", lat); end
    recv_a(0, r, errs, lasts, st);
    n_cmp++; if (r !== 64'd0 || errs !== 2'b11) begin n_bad++; $display("FAIL err_m_eq_n: got %0d err=%b want 0 err=11", r, errs); end
    n_cmp++; if (lasts !== 2'b01) begin n_bad++; $display("FAIL err_last: got %b want 01", lasts); end
    load_a(64'd0, 64'd5, 64'd1, 0);
    wait_a(lat);
    recv_a(0, r, errs, lasts, st);
    n_cmp++; if (r !== 64'd0 || errs !== 2'b11) begin n_bad++; $display("FAIL err_n_one: got %0d err=%b want 0 err=11", r, errs); end
    load_a(64'd9, 64'd3, 64'd8, 0);
    wait_a(lat);
    recv_a(0, r, errs, lasts, st);
    n_cmp++; if (r !== 64'd0 || errs !== 2'b11) begin n_bad++; $display("FAIL err_m_gt_n: got %0d err=%b want 0 err=11", r, errs); end
    n_cmp++; if (a_err !== 1'b0) begin n_bad++; $display("FAIL err_cleared: got %b want 0", a_err); end
  endtask

  task automatic test_backpressure();
    int lat; logic [63:0] r; logic [1:0] errs, lasts; bit st;
    load_a(64'd65, 64'd17, 64'd3233, 0);
    wait_a(lat);
    recv_a(10, r, errs, lasts, st);
    n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL bp_stable: got %b want 1", st); end
    n_cmp++; if (r !== 64'd2790) begin n_bad++; $display("FAIL bp_result: got %0d want 2790", r); end
    n_cmp++; if (lasts !== 2'b01) begin n_bad++; $display("FAIL bp_last: got %b want 01", lasts); end
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_extra_word: got %b want 0", a_out_valid); end
  endtask

  task automatic test_gapped_load();
    int lat; logic [63:0] r; logic [1:0] errs, lasts; bit st;
    load_a(64'd4, 64'd13, 64'd497, 3);
    wait_a(lat);
    n_cmp++; if (lat != 388) begin n_bad++; $display("FAIL gap_latency: got %0d want 388", lat); end
    recv_a(0, r, errs, lasts, st);
    n_cmp++; if (r !== 64'd445) begin n_bad++; $display("FAIL gap_result: got %0d want 445", r); end
  endtask

  task automatic test_abort();
    int lat; logic [63:0] r; logic [1:0] errs, lasts; bit st;
    load_a(64'd4, 64'd13, 64'd497, 0);
    repeat (100) @(posedge clk);
    #1;
    n_cmp++; if (a_busy !== 1'b1 || a_out_valid !== 1'b0) begin n_bad++; $display("FAIL abort_mid_busy: got busy=%b vld=%b want 1 0", a_busy, a_out_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (a_busy !== 1'b0 || a_out_valid !== 1'b0 || a_out_data !== 32'd0 || a_out_last !== 1'b0 || a_err !== 1'b0) begin
      n_bad++; $display("FAIL abort_sqr: got busy=%b vld=%b data=%h last=%b err=%b want all 0", a_busy, a_out_valid, a_out_data, a_out_last, a_err); end
    load_a(64'd7, 64'd3, 64'd7, 0);
    wait_a(lat);
    n_cmp++; if (a_err !== 1'b1 || a_out_valid !== 1'b1) begin n_bad++; $display("FAIL abort_pre_out: got err=%b vld=%b want 1 1", a_err, a_out_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (a_busy !== 1'b0 || a_out_valid !== 1'b0 || a_out_data !== 32'd0 || a_out_last !== 1'b0 || a_err !== 1'b0) begin
      n_bad++; $display("FAIL abort_out: got busy=%b vld=%b data=%h last=%b err=%b want all 0", a_busy, a_out_valid, a_out_data, a_out_last, a_err); end
    load_a(64'd4, 64'd13, 64'd497, 0);
    wait_a(lat);
    recv_a(0, r, errs, lasts, st);
    n_cmp++; if (r !== 64'd445 || errs !== 2'b00) begin n_bad++; $display("FAIL abort_followup: got %0d err=%b want 445 err=00", r, errs); end
  endtask

  task automatic test_wide();
    logic [127:0] m, e, n, exp_r, r;
    logic [31:0]  w [12];
    logic [3:0]   lasts;
    logic         err0;
    int           lat, t;
    n = {$urandom, $urandom, $urandom, $urandom};
    n[127] = 1'b1;
    n[0]   = 1'b1;
    m = {$urandom, $urandom, $urandom, $urandom} % n;
    e = '1;
    exp_r = mexp128(m, e, n);
    for (int k = 0; k < 4; k++) begin
      w[k]     = m[127 - 32 * k -: 32];
      w[k + 4] = e[127 - 32 * k -: 32];
      w[k + 8] = n[127 - 32 * k -: 32];
    end
    for (int k = 0; k < 12; k++) begin
      b_in_valid = 1'b1;
      b_in_data  = w[k];
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      b_in_data  = '0;
    end
    lat = 1;
    while (b_out_valid !== 1'b1 && lat < 40000) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat != 1 + 1 + 254 * 129 + 1) begin n_bad++; $display("FAIL wide_latency: got %0d want %0d", lat, 1 + 1 + 254 * 129 + 1); end
    r = '0; lasts = '0; err0 = b_err;
    for (int k = 0; k < 4; k++) begin
      t = 0;
      while (b_out_valid !== 1'b1 && t < 10) begin @(posedge clk); #1; t++; end
      r     = {r[95:0], b_out_data};
      lasts = {lasts[2:0], b_out_last};
      b_out_ready = 1'b1;
      @(posedge clk); #1;
      b_out_ready = 1'b0;
    end
    n_cmp++; if (r !== exp_r) begin n_bad++; $display("FAIL wide_result: got %h want %h", r, exp_r); end
    n_cmp++; if (lasts !== 4'b0001 || err0 !== 1'b0) begin n_bad++; $display("FAIL wide_last_err: got %b err=%b want 0001 err=0", lasts, err0); end
    n_cmp++; if (b_busy !== 1'b0) begin n_bad++; $display("FAIL wide_idle: got %b want 0", b_busy); end
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    test_reset();
    test_basic();
    test_toy_rsa();
    test_zero_exp();
    test_errors();
    test_backpressure();
    test_gapped_load();
    test_abort();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
